reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter INIT_VALUE, default 16'h0000, the value written to R0-R7 by the post-reset clear sequence.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = run the clear sequence after reset, 0 = skip it.
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 SHALL have ports, in this order:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- ex_req  input  1  execute-stage writeback request.
- ex_dr  input  3  execute-stage destination register.
- ex_data  input  16  execute-stage writeback data.
- ex_gnt  output  1  execute request accepted this cycle.
- mem_req  input  1  memory-stage writeback request.
- mem_dr  input  3  memory-stage destination register.
- mem_data  input  16  memory-stage writeback data.
- mem_gnt  output  1  memory request accepted this cycle.
- rf_we  output  1  register file write enable.
- rf_dr  output  3  register file destination register.
- rf_data  output  16  register file write data.
- init_busy  output  1  clear sequence in progress.

Function
REQ-005 SHALL implement a two-state FSM, INIT and ARB, plus a 3-bit clear counter cnt and a 1-bit round-robin pointer pri (0 = MEM favoured, 1 = EX favoured).
REQ-006 SHALL drive rf_we, rf_dr and rf_data from registers, so the write port lags the grant or clear step by exactly one cycle.
REQ-007 SHALL drive ex_gnt, mem_gnt and init_busy combinationally from the current state, pri and the request inputs.
REQ-008 In INIT, each edge SHALL register rf_we=1, rf_dr=cnt and rf_data=INIT_VALUE, then increment cnt.
REQ-009 On the edge where cnt=7 in INIT, the FSM SHALL move to ARB, and cnt SHALL wrap to 0.
REQ-010 In INIT, init_busy SHALL be 1 and both grants SHALL be 0, regardless of the request inputs.
REQ-011 In ARB, init_busy SHALL be 0, and the FSM SHALL remain in ARB until reset.
REQ-012 In ARB, grants SHALL be set as follows:
- Exactly one requester asserting: that requester is granted.
- Both asserting: mem_gnt=1 if pri=0, ex_gnt=1 if pri=1.
- No request: no grant.
- At most one grant SHALL be high in any cycle.
REQ-013 On each edge in ARB, the write port SHALL be registered as follows:
- Grant present: rf_we=1, and rf_dr/rf_data take the granted requester's dr/data.
- No grant: rf_we=0, and rf_dr/rf_data hold their previous values.
REQ-014 pri SHALL update only on an edge with a grant: it becomes 1 after a MEM grant and 0 after an EX grant; otherwise it holds.
REQ-015 A requester SHALL hold req, dr and data stable until it sees its grant; one grant consumes exactly one request.
REQ-016 Both requesters targeting the same dr SHALL be served as two separate writes in grant order, with no merging or dropping.
REQ-017 A requester held ungranted SHALL be granted within 2 cycles while requests from the other side continue (starvation bound).
REQ-018 dr values are 3-bit, so all 8 encodings are legal with no range check; data SHALL pass through unmodified at the full 16 bits.

Reset
REQ-019 On an edge with reset=1, the block SHALL set:
- rf_we=0, rf_dr=0, rf_data=0.
- cnt=0, pri=0.
- State INIT if CLEAR_ON_RESET=1, else ARB.
REQ-020 While reset=1, ex_gnt=0, mem_gnt=0, and init_busy=CLEAR_ON_RESET.
REQ-021 Reset asserted mid-clear or mid-arbitration SHALL abort the current activity and restart from REQ-019 on the next edge; any writes already presented are not retracted.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Clear: CLEAR_ON_RESET=1, INIT_VALUE=16'h0000; release reset -> rf_we=1 for 8 consecutive cycles with rf_dr=0..7, rf_data=0; init_busy falls after the dr=7 step; rf_we=0 next.
- Single: in ARB, ex_req=1, ex_dr=3, ex_data=16'hBEEF for one cycle -> ex_gnt=1 that cycle; next cycle rf_we=1, rf_dr=3, rf_data=16'hBEEF.
- Contention: both requesting continuously (mem: dr=1, 16'h1111; ex: dr=2, 16'h2222), pri=0 -> grants alternate MEM, EX, MEM, EX; rf_dr sequence 1,2,1,2; never both grants high.
- Same dr: both request dr=5 (mem 16'hAAAA, ex 16'h5555) -> two writes to dr=5 on consecutive cycles, 16'hAAAA then 16'h5555.
- Reset mid-clear: reset pulsed when rf_dr=4 during INIT -> rf_we=0 for the reset cycle, then a full 0..7 clear restarts.
- Skip clear: CLEAR_ON_RESET=0; release reset with mem_req=1 -> mem_gnt=1 in the first cycle, init_busy=0 throughout.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Register-file write port shared by execute and memory writeback stages.
// An optional post-reset clear sequence writes INIT_VALUE to R0-R7, and then round-robin arbitration starts.
module reg_write_arbiter #(
  parameter logic [15:0] INIT_VALUE     = 16'h0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req,
  input  logic [2:0]  ex_dr,
  input  logic [15:0] ex_data,
  output logic        ex_gnt,
  input  logic        mem_req,
  input  logic [2:0]  mem_dr,
  input  logic [15:0] mem_data,
  output logic        mem_gnt,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_data,
  output logic        init_busy
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_ARB  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_pri;
  logic                w_ex_gnt;
  logic                w_mem_gnt;
  logic                w_init_busy;
  logic                r_wr_vld_p1;
  logic [ADDR_W-1:0]   r_wr_dr_p1;
  logic [DATA_W-1:0]   r_wr_data_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR_ON_RESET ? S_INIT : S_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_cnt == 3'd7) begin
      w_state_nxt = S_ARB;
    end
  end

  // Grants are combinational; on contention, r_pri picks the side not served most recently.
  always_comb begin
    w_ex_gnt    = 1'b0;
    w_mem_gnt   = 1'b0;
    w_init_busy = 1'b0;
    if (reset) begin
      w_init_busy = CLEAR_ON_RESET;
    end else if (r_state == S_INIT) begin
      w_init_busy = 1'b1;
    end else begin
      w_mem_gnt = mem_req & (~ex_req | ~r_pri);
      w_ex_gnt  = ex_req & (~mem_req | r_pri);
    end
  end

  // Stage p1: registered write port, one cycle behind the grant or clear step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_vld_p1  <= 1'b0;
      r_wr_dr_p1   <= '0;
      r_wr_data_p1 <= '0;
      r_cnt        <= '0;
      r_pri        <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_wr_vld_p1  <= 1'b1;
      r_wr_dr_p1   <= r_cnt;
      r_wr_data_p1 <= INIT_VALUE;
      r_cnt        <= r_cnt + 3'd1;
    end else begin
      r_wr_vld_p1 <= w_mem_gnt | w_ex_gnt;
      if (w_mem_gnt) begin
        r_wr_dr_p1   <= mem_dr;
        r_wr_data_p1 <= mem_data;
        r_pri        <= 1'b1;
      end else if (w_ex_gnt) begin
        r_wr_dr_p1   <= ex_dr;
        r_wr_data_p1 <= ex_data;
        r_pri        <= 1'b0;
      end
    end
  end

  assign ex_gnt    = w_ex_gnt;
  assign mem_gnt   = w_mem_gnt;
  assign init_busy = w_init_busy;
  assign rf_we     = r_wr_vld_p1;
  assign rf_dr     = r_wr_dr_p1;
  assign rf_data   = r_wr_data_p1;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios and protocol-abiding random traffic.
// Traffic is checked against a cycle-level reference model of the write-port behaviour.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ex_req, mem_req;
  logic [2:0]  ex_dr, mem_dr;
  logic [15:0] ex_data, mem_data;
  logic        ex_gnt, mem_gnt, rf_we, init_busy;
  logic [2:0]  rf_dr;
  logic [15:0] rf_data;

  logic        reset_nc, ex_req_nc, mem_req_nc;
  logic [2:0]  ex_dr_nc, mem_dr_nc;
  logic [15:0] ex_data_nc, mem_data_nc;
  logic        ex_gnt_nc, mem_gnt_nc, rf_we_nc, init_busy_nc;
  logic [2:0]  rf_dr_nc;
  logic [15:0] rf_data_nc;

  reg_write_arbiter dut (
    .clk(clk), .reset(reset),
    .ex_req(ex_req), .ex_dr(ex_dr), .ex_data(ex_data), .ex_gnt(ex_gnt),
    .mem_req(mem_req), .mem_dr(mem_dr), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data), .init_busy(init_busy)
  );

  reg_write_arbiter #(.INIT_VALUE(16'h0000), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .reset(reset_nc),
    .ex_req(ex_req_nc), .ex_dr(ex_dr_nc), .ex_data(ex_data_nc), .ex_gnt(ex_gnt_nc),
    .mem_req(mem_req_nc), .mem_dr(mem_dr_nc), .mem_data(mem_data_nc), .mem_gnt(mem_gnt_nc),
    .rf_we(rf_we_nc), .rf_dr(rf_dr_nc), .rf_data(rf_data_nc), .init_busy(init_busy_nc)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: clearing flag, clear step, who is favoured, expected write port.
  bit          m_init;
  int          m_step;
  bit          m_ex_favoured;
  bit          mg, eg;
  bit          og_mem, og_ex;
  logic        exp_we;
  logic [2:0]  exp_dr;
  logic [15:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mg = 1'b0;
    eg = 1'b0;
    if (!reset && !m_init) begin
      if (mem_req && ex_req) begin
        if (m_ex_favoured) eg = 1'b1;
        else               mg = 1'b1;
      end else begin
        mg = mem_req;
        eg = ex_req;
      end
    end
    og_mem = mem_gnt;
    og_ex  = ex_gnt;
    chk("mem_gnt", 32'(mem_gnt), 32'(mg));
    chk("ex_gnt", 32'(ex_gnt), 32'(eg));
    chk("init_busy", 32'(init_busy), 32'(reset ? 1'b1 : m_init));
    chk("one_grant", 32'(ex_gnt & mem_gnt), 32'd0);
    @(posedge clk);
    if (reset) begin
      exp_we = 1'b0; exp_dr = '0; exp_data = '0;
      m_step = 0; m_ex_favoured = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      exp_we = 1'b1; exp_dr = 3'(m_step); exp_data = 16'h0000;
      m_step++;
      if (m_step == 8) begin
        m_init = 1'b0;
        m_step = 0;
      end
    end else if (mg) begin
      exp_we = 1'b1; exp_dr = mem_dr; exp_data = mem_data; m_ex_favoured = 1'b1;
    end else if (eg) begin
      exp_we = 1'b1; exp_dr = ex_dr; exp_data = ex_data; m_ex_favoured = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    #1;
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    chk("rf_dr", 32'(rf_dr), 32'(exp_dr));
    chk("rf_data", 32'(rf_data), 32'(exp_data));
  endtask

  initial begin
    logic [2:0]  seq_dr [4];
    int          n_we;
    bit          mp, ep;
    int          mw, ew;

    reset = 1'b1; ex_req = 1'b0; mem_req = 1'b0;
    ex_dr = '0; mem_dr = '0; ex_data = '0; mem_data = '0;
    reset_nc = 1'b1; ex_req_nc = 1'b0; ex_dr_nc = '0; ex_data_nc = '0;
    mem_req_nc = 1'b1; mem_dr_nc = 3'd6; mem_data_nc = 16'h1234;

    // Skip-clear instance: no clear sequence, first cycle after reset already arbitrates.
    @(negedge clk);
    chk("nc_rst_gnt", 32'(mem_gnt_nc | ex_gnt_nc), 32'd0);
    chk("nc_rst_busy", 32'(init_busy_nc), 32'd0);
    @(posedge clk); #1;
    chk("nc_rst_we", 32'(rf_we_nc), 32'd0);
    reset_nc = 1'b0;
    @(negedge clk);
    chk("nc_first_mem_gnt", 32'(mem_gnt_nc), 32'd1);
    chk("nc_first_ex_gnt", 32'(ex_gnt_nc), 32'd0);
    chk("nc_busy", 32'(init_busy_nc), 32'd0);
    @(posedge clk); #1;
    chk("nc_we", 32'(rf_we_nc), 32'd1);
    chk("nc_dr", 32'(rf_dr_nc), 32'd6);
    chk("nc_data", 32'(rf_data_nc), 32'h1234);
    mem_req_nc = 1'b0;
    @(negedge clk);
    chk("nc_busy_idle", 32'(init_busy_nc), 32'd0);
    @(posedge clk); #1;
    chk("nc_we_idle", 32'(rf_we_nc), 32'd0);
    chk("nc_dr_hold", 32'(rf_dr_nc), 32'd6);

    // Main instance: reset, full clear, then directed arbitration cases.
    tick(); tick();
    reset = 1'b0;
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we && rf_dr == 3'(i)) n_we++;
    end
    chk("clear_steps", 32'(n_we), 32'd8);
    tick();
    chk("after_clear_we", 32'(rf_we), 32'd0);

    ex_req = 1'b1; ex_dr = 3'd3; ex_data = 16'hBEEF;
    tick();
    chk("single_dr", 32'(rf_dr), 32'd3);
    chk("single_data", 32'(rf_data), 32'hBEEF);
    ex_req = 1'b0;
    tick();

    mem_req = 1'b1; mem_dr = 3'd1; mem_data = 16'h1111;
    ex_req = 1'b1;  ex_dr = 3'd2;  ex_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq_dr[i] = rf_dr;
    end
    chk("contend_0", 32'(seq_dr[0]), 32'd1);
    chk("contend_1", 32'(seq_dr[1]), 32'd2);
    chk("contend_2", 32'(seq_dr[2]), 32'd1);
    chk("contend_3", 32'(seq_dr[3]), 32'd2);
    mem_req = 1'b0; ex_req = 1'b0;
    tick();

    mem_req = 1'b1; mem_dr = 3'd5; mem_data = 16'hAAAA;
    ex_req = 1'b1;  ex_dr = 3'd5;  ex_data = 16'h5555;
    tick();
    chk("same_dr_first", 32'(rf_data), 32'hAAAA);
    mem_req = 1'b0;
    tick();
    chk("same_dr_second", 32'(rf_data), 32'h5555);
    chk("same_dr_dr", 32'(rf_dr), 32'd5);
    ex_req = 1'b0;
    tick();

    // Reset pulsed mid-clear restarts the clear from R0.
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midclear_dr", 32'(rf_dr), 32'd4);
    reset = 1'b1; ex_req = 1'b1; ex_dr = 3'd7; ex_data = 16'h7777;
    tick();
    chk("midclear_rst_we", 32'(rf_we), 32'd0);
    reset = 1'b0;
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we && rf_dr == 3'(i) && rf_data == 16'h0000) n_we++;
    end
    chk("reclear_steps", 32'(n_we), 32'd8);
    tick();
    ex_req = 1'b0;
    tick();

    // Random traffic: each side holds its request until granted.
    mp = 1'b0; ep = 1'b0; mw = 0; ew = 0;
    for (int c = 0; c < 400; c++) begin
      if (!mp && ($urandom % 4) != 0) begin
        mp = 1'b1; mem_dr = 3'($urandom); mem_data = 16'($urandom);
      end
      if (!ep && ($urandom % 4) != 0) begin
        ep = 1'b1; ex_dr = 3'($urandom); ex_data = 16'($urandom);
      end
      mem_req = mp; ex_req = ep;
      tick();
      if (og_mem) begin mp = 1'b0; mw = 0; end else if (mp) mw++;
      if (og_ex)  begin ep = 1'b0; ew = 0; end else if (ep) ew++;
      if (mw > 2 || ew > 2) chk("starvation", 32'(mw > ew ? mw : ew), 32'd2);
    end
    mem_req = 1'b0; ex_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
